matrix_stream_tx: RTL
=====================

Name: matrix_stream_tx

Overview:
Transmitter side of the matrix input stream consumed by the MMM input memories. On a start command it reads matrix A (M x K, optional) and matrix B (K x N) from two synchronous-read RAM ports and emits them as an AXI-Stream. TUSER on that stream carries K and the new-A flag in the same format the receiver decodes. It is used as the stimulus/host-side feeder in front of MMM, and as a loopback source in system tests.

Parameters:
INW, 12, data word width
M, 7, rows of A
N, 9, columns of B
MAXK, 8, maximum inner dimension K
K_BITS, $clog2(MAXK+1), localparam, width of K field
A_AW, $clog2(M*MAXK), localparam, A address width
B_AW, $clog2(MAXK*N), localparam, B address width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  start command, sampled only when busy=0
start_k  in  K_BITS  K for this transfer
start_new_a  in  1  1: send A then B; 0: send B only
busy  out  1  transfer in progress
done  out  1  one-cycle pulse after last beat handshake
A_read_addr  out  A_AW  A RAM read address
A_data  in  INW  A RAM data, valid 1 cycle after address
B_read_addr  out  B_AW  B RAM read address
B_data  in  INW  B RAM data, valid 1 cycle after address
AXIS_TDATA  out  INW  stream data
AXIS_TVALID  out  1  stream valid
AXIS_TUSER  out  K_BITS+1  {K, new_A}: [K_BITS:1]=K, [0]=new_A
AXIS_TREADY  in  1  downstream ready

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high.
- Reset values: busy=0, done=0, AXIS_TVALID=0, AXIS_TDATA=0, AXIS_TUSER=0, A_read_addr=0, B_read_addr=0. All registers and buffer contents are cleared.
- FSM states:
  - IDLE. start && 1<=start_k<=MAXK latches K and new_A, then goes to SEND_A if new_A, else SEND_B.
  - start with K=0 or K>MAXK is ignored and the FSM stays in IDLE.
  - start while busy=1 is ignored.
  - SEND_A issues A addresses 0..M*K-1 in order (row-major), then goes to SEND_B.
  - SEND_B issues B addresses 0..K*N-1 in order (row-major, K rows of N), then goes to DRAIN.
  - DRAIN waits until every issued read has been handshaken, then returns to IDLE and pulses done.
- busy=1 in every state except IDLE.
- Read pipeline: RAM latency is 1 cycle. Returned words go into a 2-entry skid FIFO that feeds the output register.
  - A read is issued only if (FIFO occupancy + reads in flight + output register occupancy) < 3. No word is ever dropped.
- Latency: with the start accepted in cycle 0, the first AXIS_TVALID is high in cycle 3.
- Throughput: with TREADY held high, one beat per cycle with no bubbles until the last beat.
- AXI-Stream rules:
  - A transfer occurs when TVALID && TREADY.
  - Once TVALID rises, TDATA and TUSER hold stable until the handshake.
  - TVALID never depends combinationally on TREADY.
- TUSER is constant ({K, new_A}) on every beat of a transfer. The receiver samples it on the first beat.
- Beat count per transfer: new_A ? M*K+K*N : K*N. The A words are sent before any B word.
- done is high exactly one cycle after the final handshake. busy drops the same cycle done is high. A new start is accepted in that cycle or later.
- Back-to-back transfers: the next transfer's first TVALID obeys the 3-cycle latency from its start. There is no overlap with the previous transfer.
- Reset mid-transfer:
  - The next cycle shows TVALID=0, busy=0, state IDLE.
  - Partial data is discarded and no done pulse is generated.
  - The next start restarts from address 0.
- Address counters are sized for M*MAXK and MAXK*N. The maximum addresses are M*K-1 and K*N-1, so no wrap-around occurs.

Test Plan:
Setup for all scenarios: defaults M=7, N=9, MAXK=8; A RAM[i]=i+1, B RAM[i]=0x100+i.
1. start, K=4, new_A=1, TREADY=1 -> first TVALID 3 cycles after start. 28 beats 1..28, then 36 beats 0x100..0x123, 64 consecutive beats. TUSER=9 on all. done 1 cycle after the last beat.
2. start, K=2, new_A=0, TREADY=1 -> 18 beats 0x100..0x111, TUSER=4, no A reads issued.
3. K=4, new_A=1, TREADY random 50% -> same 64-beat sequence in order. TDATA/TUSER stable on every stalled cycle. No duplicates or losses.
4. start during busy; start with K=0; start with K=9 -> all ignored: no extra beats, busy unaffected / stays 0.
5. Reset after beat 10 of scenario 1 -> TVALID=0 and busy=0 next cycle, no done. A new start K=1, new_A=1 yields beats 1..7, then 0x100..0x108.
6. K=8, new_A=1, TREADY=1 -> 56 A beats, then 72 B beats (128 total), last TDATA=0x147, TUSER=17.

Source files
------------

// File: rtl/matrix_stream_tx.sv
// AXI-Stream feeder for the MMM input memories: reads A (optional) then B from synchronous-read
// RAMs and streams them with TUSER = {K, new_A}.
module matrix_stream_tx #(
  parameter int unsigned INW  = 12,
  parameter int unsigned M    = 7,
  parameter int unsigned N    = 9,
  parameter int unsigned MAXK = 8,
  localparam int unsigned K_BITS = $clog2(MAXK + 1),
  localparam int unsigned A_AW   = $clog2(M * MAXK),
  localparam int unsigned B_AW   = $clog2(MAXK * N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [K_BITS-1:0] start_k,
  input  logic              start_new_a,
  output logic              busy,
  output logic              done,
  output logic [A_AW-1:0]   A_read_addr,
  input  logic [INW-1:0]    A_data,
  output logic [B_AW-1:0]   B_read_addr,
  input  logic [INW-1:0]    B_data,
  output logic [INW-1:0]    AXIS_TDATA,
  output logic              AXIS_TVALID,
  output logic [K_BITS:0]   AXIS_TUSER,
  input  logic              AXIS_TREADY
);

  typedef enum logic [1:0] {StIdle, StSendA, StSendB, StDrain} state_e;

  state_e            state_q, state_d;
  logic [A_AW-1:0]   a_addr_q, a_last_q;
  logic [B_AW-1:0]   b_addr_q, b_last_q;
  logic              rd_vld_q, rd_src_q;
  logic [INW-1:0]    fifo_mem_q [2];
  logic              fifo_wr_q, fifo_rd_q;
  logic [1:0]        fifo_cnt_q;
  logic              out_vld_q;
  logic [INW-1:0]    out_data_q;
  logic [K_BITS:0]   user_q;
  logic              done_q;

  logic              start_ok, accept, issue_a, issue_b, done_d;
  logic [2:0]        occ;
  logic              credit, out_free, bypass, fifo_push, fifo_pop, last_hs;
  logic [INW-1:0]    ret_data;

  assign start_ok = start && (start_k != '0) && (32'(start_k) <= MAXK);

  // Words owned by the pipeline; capped at 3 so the 2-entry FIFO can never overflow.
  assign occ      = {1'b0, fifo_cnt_q} + {2'b00, rd_vld_q} + {2'b00, out_vld_q};
  assign credit   = occ < 3'd3;
  assign out_free = !out_vld_q || AXIS_TREADY;
  assign ret_data = rd_src_q ? B_data : A_data;

  // Returning words skip the FIFO when it is empty and the output register can take them.
  assign fifo_pop  = out_free && (fifo_cnt_q != 2'd0);
  assign bypass    = out_free && (fifo_cnt_q == 2'd0) && rd_vld_q;
  assign fifo_push = rd_vld_q && !bypass;
  assign last_hs   = out_vld_q && AXIS_TREADY && (fifo_cnt_q == 2'd0) && !rd_vld_q;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue_a = 1'b0;
    issue_b = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          accept  = 1'b1;
          state_d = start_new_a ? StSendA : StSendB;
        end
      end
      StSendA: begin
        if (credit) begin
          issue_a = 1'b1;
          if (a_addr_q == a_last_q) state_d = StSendB;
        end
      end
      StSendB: begin
        if (credit) begin
          issue_b = 1'b1;
          if (b_addr_q == b_last_q) state_d = StDrain;
        end
      end
      StDrain: begin
        if (last_hs) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      a_addr_q      <= '0;
      a_last_q      <= '0;
      b_addr_q      <= '0;
      b_last_q      <= '0;
      rd_vld_q      <= 1'b0;
      rd_src_q      <= 1'b0;
      fifo_mem_q[0] <= '0;
      fifo_mem_q[1] <= '0;
      fifo_wr_q     <= 1'b0;
      fifo_rd_q     <= 1'b0;
      fifo_cnt_q    <= 2'd0;
      out_vld_q     <= 1'b0;
      out_data_q    <= '0;
      user_q        <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      rd_vld_q <= issue_a || issue_b;
      rd_src_q <= issue_b;

      if (accept) begin
        user_q   <= {start_k, start_new_a};
        a_addr_q <= '0;
        b_addr_q <= '0;
        a_last_q <= A_AW'(M * 32'(start_k) - 32'd1);
        b_last_q <= B_AW'(N * 32'(start_k) - 32'd1);
      end
      if (issue_a && (a_addr_q != a_last_q)) a_addr_q <= a_addr_q + A_AW'(1);
      if (issue_b && (b_addr_q != b_last_q)) b_addr_q <= b_addr_q + B_AW'(1);

      if (fifo_push) begin
        fifo_mem_q[fifo_wr_q] <= ret_data;
        fifo_wr_q             <= ~fifo_wr_q;
      end
      if (fifo_pop) fifo_rd_q <= ~fifo_rd_q;
      if (fifo_push && !fifo_pop) begin
        fifo_cnt_q <= fifo_cnt_q + 2'd1;
      end else if (!fifo_push && fifo_pop) begin
        fifo_cnt_q <= fifo_cnt_q - 2'd1;
      end

      if (out_free) begin
        if (fifo_pop) begin
          out_vld_q  <= 1'b1;
          out_data_q <= fifo_mem_q[fifo_rd_q];
        end else if (bypass) begin
          out_vld_q  <= 1'b1;
          out_data_q <= ret_data;
        end else begin
          out_vld_q  <= 1'b0;
        end
      end
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign A_read_addr = a_addr_q;
  assign B_read_addr = b_addr_q;
  assign AXIS_TDATA  = out_data_q;
  assign AXIS_TVALID = out_vld_q;
  assign AXIS_TUSER  = user_q;

endmodule
